// File: rtl/time_set_ctrl.sv
// Front-panel key controller: debounces KEY inputs, sequences RUN/SET_HOUR/SET_MIN,
// emits registered single-cycle field pulses with auto-repeat, idle timeout and blink.
module time_set_ctrl #(
  parameter int DEB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES    = 25000000,
  parameter int REPEAT_CYCLES  = 5000000,
  parameter int BLINK_CYCLES   = 12500000,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int CNT_W          = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  output logic       run_en,
  output logic       hour_add,
  output logic       hour_reduce,
  output logic       min_add,
  output logic       min_reduce,
  output logic       sec_clear,
  output logic       blink_hour,
  output logic       blink_min,
  output logic [1:0] mode_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  // Key index: 0 = mode, 1 = up, 2 = down. All raw levels are active-low.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb_lvl;
  logic [2:0]       armed;
  logic [2:0]       press;
  logic [CNT_W-1:0] deb_cnt [3];

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_tog;

  logic             up_p;
  logic             dn_p;
  logic             in_set;
  logic             single;
  logic             rep;
  logic             any_evt;
  logic             inc;
  logic             dec;
  logic             clr_sec;
  logic             state_chg;

  assign raw = {key_down, key_up, key_mode};

  // Synchronizers reset to "pressed" so a key held through reset never looks like a
  // fresh press; a key only arms once it has been seen released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 3'b000;
      sync2   <= 3'b000;
      deb_lvl <= 3'b111;
      armed   <= 3'b000;
      press   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb_lvl[i] <= sync2[i];
          press[i]   <= armed[i] & ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
        if (deb_lvl[i] && sync2[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign up_p = ~deb_lvl[1];
  assign dn_p = ~deb_lvl[2];

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    dec       = 1'b0;
    clr_sec   = 1'b0;
    in_set    = (state != RUN);
    single    = up_p ^ dn_p;
    rep       = in_set && single && (hold_cnt == HOLD_LAST);
    any_evt   = (|press) || rep;
    if (press[0]) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN: begin
          state_nxt = RUN;
          clr_sec   = 1'b1;
        end
        default:  state_nxt = RUN;
      endcase
    end else if (in_set) begin
      // A press while the other key is down means both are held: suppressed.
      inc = (press[1] && !dn_p) || (rep && up_p);
      dec = (press[2] && !up_p) || (rep && dn_p);
      if (!any_evt && idle_cnt == TMO_LAST) state_nxt = RUN;
    end
    state_chg = (state_nxt != state);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      hold_cnt    <= '0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
      blink_tog   <= 1'b0;
      hour_add    <= 1'b0;
      hour_reduce <= 1'b0;
      min_add     <= 1'b0;
      min_reduce  <= 1'b0;
      sec_clear   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hour_add    <= inc && (state == SET_HOUR);
      hour_reduce <= dec && (state == SET_HOUR);
      min_add     <= inc && (state == SET_MIN);
      min_reduce  <= dec && (state == SET_MIN);
      sec_clear   <= clr_sec;

      // Hold timer restarts at 1 on an accepted press; repeats reload it so the
      // next repeat lands REPEAT_CYCLES later.
      if (!in_set || state_chg || (up_p && dn_p)) begin
        hold_cnt <= '0;
      end else if ((press[1] && !dn_p) || (press[2] && !up_p)) begin
        hold_cnt <= CNT_ONE;
      end else if (!single) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= HOLD_RELOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt + CNT_ONE;
      end

      if (!in_set || state_chg || any_evt) idle_cnt <= '0;
      else                                 idle_cnt <= idle_cnt + CNT_ONE;

      if (state_chg || inc || dec) begin
        blink_cnt <= '0;
        blink_tog <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_tog <= ~blink_tog;
      end else begin
        blink_cnt <= blink_cnt + CNT_ONE;
      end
    end
  end

  assign run_en     = (state == RUN);
  assign mode_state = state;
  assign blink_hour = blink_tog && (state == SET_HOUR);
  assign blink_min  = blink_tog && (state == SET_MIN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with shortened timing parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_up = 1'b1;
  logic       key_down = 1'b1;
  logic       run_en, hour_add, hour_reduce, min_add, min_reduce, sec_clear;
  logic       blink_hour, blink_min;
  logic [1:0] mode_state;

  int errors = 0;
  int checks = 0;
  int n_ha = 0, n_hr = 0, n_ma = 0, n_mr = 0, n_sc = 0, viol = 0;
  int mon_sum;
  logic any_prev = 1'b0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEB_CYCLES(4), .HOLD_CYCLES(40), .REPEAT_CYCLES(10),
    .BLINK_CYCLES(8), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .reset(reset), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .run_en(run_en), .hour_add(hour_add), .hour_reduce(hour_reduce),
    .min_add(min_add), .min_reduce(min_reduce), .sec_clear(sec_clear),
    .blink_hour(blink_hour), .blink_min(blink_min), .mode_state(mode_state)
  );

  // Pulse counters plus invariant watch: one-hot pulses, no back-to-back highs,
  // legal encoding, run_en tied to RUN.
  always @(negedge clk) begin
    mon_sum = $countones({hour_add, hour_reduce, min_add, min_reduce, sec_clear});
    if (hour_add === 1'b1)    n_ha++;
    if (hour_reduce === 1'b1) n_hr++;
    if (min_add === 1'b1)     n_ma++;
    if (min_reduce === 1'b1)  n_mr++;
    if (sec_clear === 1'b1)   n_sc++;
    if (mon_sum > 1) viol++;
    if (mon_sum > 0 && any_prev) viol++;
    if (mode_state === 2'd3) viol++;
    if (run_en !== (mode_state == 2'd0)) viol++;
    any_prev = (mon_sum > 0);
  end

  task step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task press(input int k, input int low_n, input int high_n);
    if (k == 0) key_mode = 1'b0; else if (k == 1) key_up = 1'b0; else key_down = 1'b0;
    step(low_n);
    if (k == 0) key_mode = 1'b1; else if (k == 1) key_up = 1'b1; else key_down = 1'b1;
    step(high_n);
  endtask

  task test_reset;
    int tot0;
    key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
    reset = 1'b0;
    step(3);
    checks++;
    if (mode_state !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode_state); end
    checks++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en: got %b expected 1", run_en); end
    checks++;
    if ({hour_add, hour_reduce, min_add, min_reduce, sec_clear} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000", {hour_add, hour_reduce, min_add, min_reduce, sec_clear});
    end
    tot0 = n_ha + n_hr + n_ma + n_mr + n_sc;
    reset = 1'b1;
    step(15);
    checks++;
    if (mode_state !== 2'd0) begin errors++; $display("FAIL reset_held_keys_mode: got %0d expected 0", mode_state); end
    key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
    step(10);
    checks++;
    if (n_ha + n_hr + n_ma + n_mr + n_sc !== tot0) begin
      errors++; $display("FAIL reset_exit_pulses: got %0d expected %0d", n_ha + n_hr + n_ma + n_mr + n_sc, tot0);
    end
  endtask

  task test_mode_cycle;
    int t_first, n_trans, sc0, sc_mode, sc_prev;
    logic [1:0] prev;
    t_first = -1; n_trans = 0; sc_mode = -1; sc_prev = -1;
    key_mode = 1'b0; step(2);
    key_mode = 1'b1; step(1);
    key_mode = 1'b0;
    prev = mode_state;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (mode_state !== prev) begin
        n_trans++;
        if (t_first < 0) t_first = i;
      end
      prev = mode_state;
    end
    key_mode = 1'b1;
    step(10);
    checks++;
    if (t_first < 4 || t_first > 7) begin errors++; $display("FAIL bounce_latency: got %0d expected 4..7", t_first); end
    checks++;
    if (n_trans !== 1 || mode_state !== 2'd1) begin
      errors++; $display("FAIL bounce_single_step: got trans=%0d mode=%0d expected trans=1 mode=1", n_trans, mode_state);
    end
    press(0, 8, 8);
    checks++;
    if (mode_state !== 2'd2) begin errors++; $display("FAIL mode_to_set_min: got %0d expected 2", mode_state); end
    sc0 = n_sc;
    prev = mode_state;
    key_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (sec_clear === 1'b1) begin sc_mode = mode_state; sc_prev = prev; end
      prev = mode_state;
    end
    key_mode = 1'b1;
    step(8);
    checks++;
    if (mode_state !== 2'd0) begin errors++; $display("FAIL mode_to_run: got %0d expected 0", mode_state); end
    checks++;
    if (n_sc - sc0 !== 1) begin errors++; $display("FAIL sec_clear_count: got %0d expected 1", n_sc - sc0); end
    checks++;
    if (sc_mode !== 0 || sc_prev !== 2) begin
      errors++; $display("FAIL sec_clear_timing: got mode=%0d prev=%0d expected mode=0 prev=2", sc_mode, sc_prev);
    end
  endtask

  task test_field_pulses;
    int ha0, hr0, ma0, mr0;
    press(1, 8, 8);
    press(0, 8, 8);
    ha0 = n_ha; hr0 = n_hr; ma0 = n_ma; mr0 = n_mr;
    for (int i = 0; i < 3; i++) press(1, 8, 8);
    checks++;
    if (n_ha - ha0 !== 3) begin errors++; $display("FAIL hour_add_count: got %0d expected 3", n_ha - ha0); end
    checks++;
    if (n_hr - hr0 + n_ma - ma0 + n_mr - mr0 !== 0) begin
      errors++; $display("FAIL hour_other_pulses: got %0d expected 0", n_hr - hr0 + n_ma - ma0 + n_mr - mr0);
    end
    press(0, 8, 8);
    checks++;
    if (mode_state !== 2'd2) begin errors++; $display("FAIL field_set_min: got %0d expected 2", mode_state); end
    ma0 = n_ma; mr0 = n_mr;
    press(2, 8, 8);
    checks++;
    if (n_mr - mr0 !== 1 || n_ma - ma0 !== 0) begin
      errors++; $display("FAIL min_reduce_count: got reduce=%0d add=%0d expected 1 and 0", n_mr - mr0, n_ma - ma0);
    end
  endtask

  task test_auto_repeat;
    int first, npulse, ma0, mr0;
    int offs[8];
    int exp_off[5];
    exp_off = '{0, 40, 50, 60, 70};
    for (int i = 0; i < 8; i++) offs[i] = -1;
    first = -1; npulse = 0; mr0 = n_mr;
    key_up = 1'b0;
    for (int c = 0; c < 130; c++) begin
      step(1);
      if (min_add === 1'b1) begin
        if (first < 0) first = c;
        if (npulse < 8) offs[npulse] = c - first;
        npulse++;
      end
      if (first >= 0 && c == first + 72) key_up = 1'b1;
    end
    key_up = 1'b1;
    step(10);
    checks++;
    if (npulse !== 5) begin errors++; $display("FAIL repeat_count: got %0d expected 5", npulse); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (offs[i] !== exp_off[i]) begin
        errors++; $display("FAIL repeat_offset_%0d: got %0d expected %0d", i, offs[i], exp_off[i]);
      end
    end
    checks++;
    if (n_mr - mr0 !== 0) begin errors++; $display("FAIL repeat_reduce: got %0d expected 0", n_mr - mr0); end

    first = -1;
    key_up = 1'b0;
    for (int c = 0; c < 20 && first < 0; c++) begin
      step(1);
      if (min_add === 1'b1) first = c;
    end
    checks++;
    if (first < 0) begin errors++; $display("FAIL dual_first_pulse: got none expected one within 20 cycles"); end
    step(4);
    key_down = 1'b0;
    ma0 = n_ma; mr0 = n_mr;
    step(60);
    checks++;
    if (n_ma - ma0 !== 0 || n_mr - mr0 !== 0) begin
      errors++; $display("FAIL dual_suppress: got add=%0d reduce=%0d expected 0 and 0", n_ma - ma0, n_mr - mr0);
    end
    key_up = 1'b1; key_down = 1'b1;
    step(12);
    press(0, 8, 8);
    checks++;
    if (mode_state !== 2'd0) begin errors++; $display("FAIL repeat_exit_run: got %0d expected 0", mode_state); end
  endtask

  task test_timeout_blink;
    int sc0, found;
    sc0 = n_sc; found = 0;
    key_mode = 1'b0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      step(1);
      if (mode_state === 2'd1) found = 1;
    end
    key_mode = 1'b1;
    checks++;
    if (found == 0) begin errors++; $display("FAIL timeout_enter: got mode=%0d expected 1", mode_state); end
    for (int k = 0; k <= 205; k++) begin
      if (k > 0) step(1);
      if (k == 0 || k == 7 || k == 16) begin
        checks++;
        if (blink_hour !== 1'b0) begin errors++; $display("FAIL blink_low_%0d: got %b expected 0", k, blink_hour); end
      end
      if (k == 8 || k == 15) begin
        checks++;
        if (blink_hour !== 1'b1) begin errors++; $display("FAIL blink_high_%0d: got %b expected 1", k, blink_hour); end
        checks++;
        if (blink_min !== 1'b0) begin errors++; $display("FAIL blink_min_%0d: got %b expected 0", k, blink_min); end
      end
      if (k == 199) begin
        checks++;
        if (mode_state !== 2'd1) begin errors++; $display("FAIL timeout_early: got %0d expected 1", mode_state); end
      end
      if (k == 200) begin
        checks++;
        if (mode_state !== 2'd0 || run_en !== 1'b1) begin
          errors++; $display("FAIL timeout_run: got mode=%0d run_en=%b expected 0 and 1", mode_state, run_en);
        end
      end
    end
    checks++;
    if (n_sc !== sc0) begin errors++; $display("FAIL timeout_sec_clear: got %0d expected %0d", n_sc - sc0, 0); end
  endtask

  task test_priority;
    int ha0, ma0;
    press(0, 8, 8);
    ha0 = n_ha; ma0 = n_ma;
    key_mode = 1'b0; key_up = 1'b0;
    step(8);
    checks++;
    if (mode_state !== 2'd2) begin errors++; $display("FAIL priority_mode: got %0d expected 2", mode_state); end
    key_mode = 1'b1; key_up = 1'b1;
    step(10);
    checks++;
    if (n_ha - ha0 !== 0 || n_ma - ma0 !== 0) begin
      errors++; $display("FAIL priority_no_pulse: got hour=%0d min=%0d expected 0 and 0", n_ha - ha0, n_ma - ma0);
    end
  endtask

  task test_reset_mid;
    int tot0;
    key_up = 1'b0;
    step(27);
    tot0 = n_ha + n_hr + n_ma + n_mr + n_sc;
    reset = 1'b0;
    step(1);
    checks++;
    if (mode_state !== 2'd0 || run_en !== 1'b1) begin
      errors++; $display("FAIL midreset_run: got mode=%0d run_en=%b expected 0 and 1", mode_state, run_en);
    end
    step(2);
    reset = 1'b1;
    step(60);
    key_up = 1'b1;
    step(10);
    checks++;
    if (n_ha + n_hr + n_ma + n_mr + n_sc !== tot0) begin
      errors++; $display("FAIL midreset_pulses: got %0d expected %0d", n_ha + n_hr + n_ma + n_mr + n_sc, tot0);
    end
    checks++;
    if (mode_state !== 2'd0) begin errors++; $display("FAIL midreset_mode: got %0d expected 0", mode_state); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL invariants: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_field_pulses();
    test_auto_repeat();
    test_timeout_blink();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
